mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_arith.sv | 61 ++++++
 rtl/mdu_sequencer.sv | 118 +++++++++++
 tb/tb_mdu_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM encoding, counter width and default latencies.
package mdu_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; div0 flags a divide by zero and zeroes the raw results.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic        is_signed;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    hi_res    = '0;
    lo_res    = '0;
    div0      = 1'b0;
    prod      = '0;
    // Divide on magnitudes so INT_MIN / -1 and sign handling are explicit.
    mag_a     = (is_signed && rs[31]) ? (~rs + 32'd1) : rs;
    mag_b     = (is_signed && rt[31]) ? (~rt + 32'd1) : rt;
    mag_q     = '0;
    mag_r     = '0;
    neg_q     = is_signed && (rs[31] ^ rt[31]);
    neg_r     = is_signed && rs[31];

    case (op)
      OP_MULT: begin
        prod = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      OP_MULTU: begin
        prod = {32'd0, rs} * {32'd0, rt};
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (rt == 32'd0) begin
          div0 = 1'b1;
        end else begin
          mag_q  = mag_a / mag_b;
          mag_r  = mag_a % mag_b;
          lo_res = neg_q ? (~mag_q + 32'd1) : mag_q;
          hi_res = neg_r ? (~mag_r + 32'd1) : mag_r;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MDU sequencer: IDLE/RUN FSM, latency counter, pending result and HI/LO registers.
// Build option MDU_DIV0_HOLD_EN: divide by zero runs full latency but leaves HI/LO untouched.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        pend_hi_q;
  logic [31:0]        pend_lo_q;
  logic               commit_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic [31:0]        hi_res;
  logic [31:0]        lo_res;
  logic               div0;
  logic               is_div;
  logic               launch;
  logic [CNT_W-1:0]   cnt_d;
  logic [31:0]        pend_hi_d;
  logic [31:0]        pend_lo_d;
  logic               commit_d;

  mdu_arith u_arith (
    .op     (md_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign launch = start && !flush &&
                  (md_op == OP_MULT || md_op == OP_MULTU || is_div);
  assign cnt_d  = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

`ifdef MDU_DIV0_HOLD_EN
  assign pend_hi_d = hi_res;
  assign pend_lo_d = lo_res;
  assign commit_d  = !div0;
`else
  assign pend_hi_d = div0 ? rs_val : hi_res;
  assign pend_lo_d = div0 ? 32'hFFFF_FFFF : lo_res;
  assign commit_d  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      commit_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q   <= ST_RUN;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
          end else if (!flush && md_op == OP_MTHI) begin
            hi_q <= rs_val;
          end else if (!flush && md_op == OP_MTLO) begin
            lo_q <= rs_val;
          end
        end
        ST_RUN: begin
          // Flush and new requests are deliberately ignored until the op commits.
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            if (commit_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign stall_req = d_md_use && (busy || start);
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    md_rdata = '0;
    if (md_op == OP_MFHI)      md_rdata = hi_q;
    else if (md_op == OP_MFLO) md_rdata = lo_q;
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with default latencies (mult 5, div 10).
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  mdu_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .md_op     (md_op),
    .start     (start),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .md_rdata  (md_rdata),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch op, then verify busy/stall and unchanged HI/LO for n cycles and idle afterwards.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    md_op = op; start = 1'b1; rs_val = a; rt_val = b;
    #1;
    check({tag, "_stall_start"}, {31'd0, stall_req}, {31'd0, d_md_use});
    tick();
    md_op = OP_NONE; start = 1'b0; rs_val = '0; rt_val = '0;
    #1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_stall_busy"}, {31'd0, stall_req}, {31'd0, d_md_use});
      check({tag, "_hi_hold"}, hi, h0);
      check({tag, "_lo_hold"}, lo, l0);
      tick();
    end
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    $display("txn %s op=%0d rs=%h rt=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
  endtask

  initial begin
    reset_n = 1'b0; md_op = OP_NONE; start = 1'b0; rs_val = '0; rt_val = '0;
    flush = 1'b0; d_md_use = 1'b0;
    tick();
    tick();

    // Post-reset state
    reset_n = 1'b1; md_op = OP_MFHI; d_md_use = 1'b1;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", md_rdata, 32'd0);
    check("rst_stall_nostart", {31'd0, stall_req}, 32'd0);
    start = 1'b1; md_op = OP_NONE;
    #1;
    check("rst_stall_start", {31'd0, stall_req}, 32'd1);
    start = 1'b0; d_md_use = 1'b0;

    // mult -2 * 3
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    md_op = OP_MFHI; #1;
    check("mfhi", md_rdata, 32'hFFFF_FFFF);
    md_op = OP_MFLO; #1;
    check("mflo", md_rdata, 32'hFFFF_FFFA);
    md_op = OP_NONE;

    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, "multu");
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    run_op(OP_DIVU, 32'd100, 32'd7, 10, "divu");
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Signed divide -7 / 2 with a D-stage MDU op waiting
    d_md_use = 1'b1;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_stall_after", {31'd0, stall_req}, 32'd0);
    d_md_use = 1'b0;

    // 2*3 with flush and mthi arriving while busy: must still commit and ignore mthi
    md_op = OP_MULT; start = 1'b1; rs_val = 32'd2; rt_val = 32'd3;
    tick();
    start = 1'b0; flush = 1'b1; md_op = OP_MTHI; rs_val = 32'h9999; rt_val = '0;
    tick();
    tick();
    flush = 1'b0;
    check("runflush_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    tick();
    md_op = OP_NONE; rs_val = '0;
    #1;
    check("runflush_done", {31'd0, busy}, 32'd0);
    check("runflush_hi", hi, 32'd0);
    check("runflush_lo", lo, 32'd6);
    $display("txn mult-with-flush -> hi=%h lo=%h", hi, lo);

    // flush suppresses start and mthi
    md_op = OP_MULT; start = 1'b1; flush = 1'b1; rs_val = 32'd5; rt_val = 32'd5;
    tick();
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; md_op = OP_MTHI; rs_val = 32'h1234; rt_val = '0;
    tick();
    check("flush_mthi_hi", hi, 32'd0);
    check("flush_lo", lo, 32'd6);
    flush = 1'b0;
    tick();
    check("mthi_hi", hi, 32'h1234);
    md_op = OP_MTLO; rs_val = 32'hABCD;
    tick();
    check("mtlo_lo", lo, 32'hABCD);
    md_op = OP_NONE; rs_val = '0;
    $display("txn flush/mthi/mtlo -> hi=%h lo=%h", hi, lo);

    // Reset in the middle of a div: abort without a late commit
    md_op = OP_DIVU; start = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    md_op = OP_NONE; start = 1'b0; rs_val = '0; rt_val = '0;
    tick();
    tick();
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("midrst_late_hi", hi, 32'd0);
    check("midrst_late_lo", lo, 32'd0);
    check("midrst_late_busy", {31'd0, busy}, 32'd0);
    $display("txn divu reset mid-op -> hi=%h lo=%h", hi, lo);

    // Divide by zero
    md_op = OP_MTHI; rs_val = 32'h11;
    tick();
    md_op = OP_MTLO; rs_val = 32'h22;
    tick();
    md_op = OP_NONE; rs_val = '0;
    run_op(OP_DIV, 32'h55, 32'd0, 10, "div0");
`ifdef MDU_DIV0_HOLD_EN
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
`else
    check("div0_hi", hi, 32'h55);
    check("div0_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
